// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage.
//
// Contents:
//   - RV32I load/store width codes (funct3)
//   - bus strobe width
//   - FSM state encoding for lsu_mem_stage
//   - funct3_illegal(): flags width codes that no RV32I load/store uses
package lsu_mem_stage_pkg;

  // Data bus geometry
  localparam int unsigned DataW  = 32;
  localparam int unsigned StrbW  = DataW / 8;

  // RV32I load/store width codes
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3BU = 3'b100;
  localparam logic [2:0] Funct3HU = 3'b101;

  // Access FSM
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  // 011, 110 and 111 are not load/store widths.
  function automatic logic funct3_illegal(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational data alignment for the load/store stage.
//
// Request side (driven from the live core request):
//   req_we_i      1   1 = store, 0 = load
//   req_funct3_i  3   RV32I width code
//   req_off_i     2   byte offset inside the word (addr[1:0])
//   req_wdata_i   32  store data as read from rs2
//   misalign_o    1   access is misaligned or the width code is illegal
//   wstrb_o       4   byte strobes for the bus (all zero for loads)
//   wdata_o       32  store data replicated onto every byte lane it may occupy
//
// Load side (driven from the latched request and the bus read data):
//   ld_funct3_i   3   latched width code
//   ld_off_i      2   latched byte offset
//   ld_rdata_i    32  raw read word from the bus
//   ld_data_o     32  shifted and sign/zero-extended load result
module lsu_mem_stage_align
  import lsu_mem_stage_pkg::*;
(
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [1:0]        req_off_i,
  input  logic [DataW-1:0]  req_wdata_i,
  output logic              misalign_o,
  output logic [StrbW-1:0]  wstrb_o,
  output logic [DataW-1:0]  wdata_o,

  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [DataW-1:0]  ld_rdata_i,
  output logic [DataW-1:0]  ld_data_o
);

  logic [DataW-1:0] ld_shifted;

  // Store lanes and alignment check. Only funct3[1:0] selects the width; the
  // illegal codes are caught separately below.
  always_comb begin
    misalign_o = 1'b0;
    wstrb_o    = '0;
    wdata_o    = req_wdata_i;
    unique case (req_funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{req_wdata_i[7:0]}};
        wstrb_o = 4'b0001 << req_off_i;
      end
      2'b01: begin
        misalign_o = req_off_i[0];
        wdata_o    = {2{req_wdata_i[15:0]}};
        wstrb_o    = 4'b0011 << req_off_i;
      end
      2'b10: begin
        misalign_o = |req_off_i;
        wstrb_o    = 4'b1111;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
    if (funct3_illegal(req_funct3_i)) begin
      misalign_o = 1'b1;
    end
    if (!req_we_i) begin
      wstrb_o = '0;
    end
  end

  // Load extraction: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    unique case (ld_funct3_i)
      Funct3B:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      Funct3H:  ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      Funct3BU: ld_data_o = {24'h000000, ld_shifted[7:0]};
      Funct3HU: ld_data_o = {16'h0000, ld_shifted[15:0]};
      default:  ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage.
//
// Takes the ALU result as effective address and runs one data-memory transaction
// per load/store over a req/gnt/rvalid bus. The core is stalled through lsu_busy
// until the access ends; lsu_done pulses for one cycle with the extended load data.
// Misaligned or illegal accesses finish without touching the bus, and an access
// that spends TIMEOUT_CYC cycles in REQ+WAIT is aborted with lsu_timeout.
//
// Parameters:
//   TIMEOUT_CYC   cycles allowed in REQ+WAIT before abort (>= 2)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/we/funct3/addr/wdata core request, held stable until lsu_done
//   lsu_busy                      stall (combinational)
//   lsu_done                      one-cycle completion pulse
//   lsu_rdata                     extended load data (0 for stores and faults)
//   lsu_misalign, lsu_timeout     fault flags, valid with lsu_done
//   mem_req/we/addr/wstrb/wdata   bus request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata bus responses
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [DataW-1:0]  req_addr,
  input  logic [DataW-1:0]  req_wdata,

  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [DataW-1:0]  lsu_rdata,
  output logic              lsu_misalign,
  output logic              lsu_timeout,

  output logic              mem_req,
  output logic              mem_we,
  output logic [DataW-1:0]  mem_addr,
  output logic [StrbW-1:0]  mem_wstrb,
  output logic [DataW-1:0]  mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DataW-1:0]  mem_rdata
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  lsu_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_inc;
  logic             cnt_hit;

  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             mem_req_q;
  logic             mem_we_q;
  logic [DataW-1:0] mem_addr_q;
  logic [StrbW-1:0] mem_wstrb_q;
  logic [DataW-1:0] mem_wdata_q;

  logic             done_q;
  logic [DataW-1:0] rdata_q;
  logic             misalign_q;
  logic             timeout_q;

  logic             st_misalign;
  logic [StrbW-1:0] st_wstrb;
  logic [DataW-1:0] st_wdata;
  logic [DataW-1:0] ld_data;

  lsu_mem_stage_align u_align (
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_off_i    (req_addr[1:0]),
    .req_wdata_i  (req_wdata),
    .misalign_o   (st_misalign),
    .wstrb_o      (st_wstrb),
    .wdata_o      (st_wdata),
    .ld_funct3_i  (funct3_q),
    .ld_off_i     (off_q),
    .ld_rdata_i   (mem_rdata),
    .ld_data_o    (ld_data)
  );

  // cnt_q counts completed REQ/WAIT cycles; the cycle that would make it reach
  // TIMEOUT_CYC aborts instead, unless the bus completes in that same cycle.
  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_hit = (cnt_inc == CntMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cnt_q <= '0;
            if (st_misalign) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q     <= StReq;
              funct3_q    <= req_funct3;
              off_q       <= req_addr[1:0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wstrb_q <= st_wstrb;
              mem_wdata_q <= st_wdata;
            end
          end
        end

        StReq: begin
          if (mem_gnt && (mem_we_q || mem_rvalid)) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            rdata_q   <= mem_we_q ? '0 : ld_data;
          end else if (cnt_hit) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            mem_req_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
            if (mem_gnt) begin
              state_q   <= StWait;
              mem_req_q <= 1'b0;
            end
          end
        end

        StWait: begin
          if (mem_rvalid) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            rdata_q <= ld_data;
          end else if (cnt_hit) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StDone: begin
          // The core advances past this instruction on this edge.
          state_q    <= StIdle;
          done_q     <= 1'b0;
          rdata_q    <= '0;
          misalign_q <= 1'b0;
          timeout_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign lsu_busy = ((state_q == StIdle) && req_valid) ||
                    (state_q == StReq) || (state_q == StWait);

  assign lsu_done     = done_q;
  assign lsu_rdata    = rdata_q;
  assign lsu_misalign = misalign_q;
  assign lsu_timeout  = timeout_q;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule
